// File: rtl/if_id_skid_buf.sv
// if_id_skid_buf: elastic IF->ID register, valid/ready on both sides, optional 2-entry skid, flush bubble
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous active-low reset
//  in_valid_i   in   1       fetch presents inst_i/inst_addr_i
//  in_ready_o   out  1       buffer can accept this cycle
//  inst_i       in   INST_W  fetched instruction
//  inst_addr_i  in   ADDR_W  address of inst_i
//  flush_i      in   1       discard all held entries
//  hold_flag_i  in   1       control stall, blocks output transfer
//  out_valid_o  out  1       head entry valid
//  out_ready_i  in   1       decode accepts head
//  inst_o       out  INST_W  head instruction or NOP_INST
//  inst_addr_o  out  ADDR_W  head address or 0
//  occupancy_o  out  2       entries held
module if_id_skid_buf #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013),
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  input  logic              hold_flag_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [1:0]        occupancy_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state, state_nxt;
  logic [INST_W-1:0] main_inst, skid_inst;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic in_fire, out_fire, load_main, load_skid, main_from_skid;
  assign out_valid_o = state != EMPTY;
  assign out_fire    = out_valid_o & out_ready_i & ~hold_flag_i;
  // With the skid, ready comes only from state so upstream never sees a path from decode.
  assign in_ready_o  = (SKID_EN != 0) ? (state != TWO) : (~out_valid_o | out_fire);
  assign in_fire     = in_valid_i & in_ready_o;
  assign inst_o      = out_valid_o ? main_inst : NOP_INST;
  assign inst_addr_o = out_valid_o ? main_addr : '0;
  assign occupancy_o = state;
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        state_nxt = in_fire ? ONE : EMPTY;
        load_main = in_fire;
      end
      ONE: begin
        state_nxt = (in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE;
        load_main = in_fire & out_fire;
        load_skid = in_fire & ~out_fire;
      end
      TWO: begin
        state_nxt = out_fire ? ONE : TWO;
        main_from_skid = out_fire;
      end
      default: state_nxt = EMPTY;
    endcase
    // Data loads may still happen under flush; the entries are invalidated anyway.
    if (flush_i) state_nxt = EMPTY;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk) begin
    if (main_from_skid) begin
      main_inst <= skid_inst;
      main_addr <= skid_addr;
    end else if (load_main) begin
      main_inst <= inst_i;
      main_addr <= inst_addr_i;
    end
    if (load_skid) begin
      skid_inst <= inst_i;
      skid_addr <= inst_addr_i;
    end
  end
endmodule

// File: tb/tb_if_id_skid_buf.sv
// tb_if_id_skid_buf: checks skid and non-skid builds against a queue model plus a vector table
module tb_if_id_skid_buf;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 1'b0;
  logic rst, iv, fl, hold, ordy;
  logic [31:0] inst, addr;
  logic ir1, ov1, ir0, ov0;
  logic [31:0] io1, ao1, io0, ao0;
  logic [1:0] oc1, oc0;
  logic [63:0] q1[$], q0[$];
  bit if1, of1, if0, of0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  if_id_skid_buf #(.SKID_EN(1)) d1 (
    .clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir1), .inst_i(inst), .inst_addr_i(addr),
    .flush_i(fl), .hold_flag_i(hold), .out_valid_o(ov1), .out_ready_i(ordy), .inst_o(io1),
    .inst_addr_o(ao1), .occupancy_o(oc1));
  if_id_skid_buf #(.SKID_EN(0)) d0 (
    .clk(clk), .rst(rst), .in_valid_i(iv), .in_ready_o(ir0), .inst_i(inst), .inst_addr_i(addr),
    .flush_i(fl), .hold_flag_i(hold), .out_valid_o(ov0), .out_ready_i(ordy), .inst_o(io0),
    .inst_addr_o(ao0), .occupancy_o(oc0));
  typedef struct {
    logic iv; logic [31:0] inst, addr; logic ordy;
    logic ov; logic [31:0] ei, ea; logic [1:0] eo; logic ir;
  } vec_t;
  vec_t tbl[7];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic check_one(input string t, input logic [63:0] q[$], input bit skid,
                           input logic ir, input logic ov, input logic [31:0] io,
                           input logic [31:0] ao, input logic [1:0] oc);
    bit v = q.size() > 0;
    bit of = v & ordy & ~hold;
    chk({t, ".valid"}, 32'(ov), 32'(v));
    chk({t, ".inst"}, io, v ? q[0][63:32] : NOP);
    chk({t, ".addr"}, ao, v ? q[0][31:0] : 32'h0);
    chk({t, ".occ"}, 32'(oc), q.size());
    chk({t, ".ready"}, 32'(ir), skid ? 32'(q.size() < 2) : 32'(!v || of));
  endtask
  task automatic pre(input logic v, input logic [31:0] i, input logic [31:0] a,
                     input logic f, input logic h, input logic r);
    @(negedge clk);
    iv = v; inst = i; addr = a; fl = f; hold = h; ordy = r;
    #1;
    check_one("skid", q1, 1'b1, ir1, ov1, io1, ao1, oc1);
    check_one("noskid", q0, 1'b0, ir0, ov0, io0, ao0, oc0);
    of1 = q1.size() > 0 && ordy && !hold;
    if1 = iv && q1.size() < 2;
    of0 = q0.size() > 0 && ordy && !hold;
    if0 = iv && (q0.size() == 0 || of0);
  endtask
  task automatic post();
    @(posedge clk);
    if (fl) begin
      q1.delete(); q0.delete();
    end else begin
      if (of1) void'(q1.pop_front());
      if (if1) q1.push_back({inst, addr});
      if (of0) void'(q0.pop_front());
      if (if0) q0.push_back({inst, addr});
    end
  endtask
  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] a,
                      input logic f, input logic h, input logic r);
    pre(v, i, a, f, h, r);
    post();
  endtask
  initial begin
    tbl[0] = '{1'b1, 32'hA0, 32'h10, 1'b0, 1'b0, NOP,   32'h0,  2'd0, 1'b1};
    tbl[1] = '{1'b1, 32'hB0, 32'h14, 1'b0, 1'b1, 32'hA0, 32'h10, 2'd1, 1'b1};
    tbl[2] = '{1'b1, 32'hC0, 32'h18, 1'b0, 1'b1, 32'hA0, 32'h10, 2'd2, 1'b0};
    tbl[3] = '{1'b1, 32'hC0, 32'h18, 1'b1, 1'b1, 32'hA0, 32'h10, 2'd2, 1'b0};
    tbl[4] = '{1'b1, 32'hC0, 32'h18, 1'b1, 1'b1, 32'hB0, 32'h14, 2'd1, 1'b1};
    tbl[5] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b1, 32'hC0, 32'h18, 2'd1, 1'b1};
    tbl[6] = '{1'b0, 32'h0,  32'h0,  1'b1, 1'b0, NOP,   32'h0,  2'd0, 1'b1};
    rst = 1'b1; iv = 0; fl = 0; hold = 0; ordy = 0; inst = 0; addr = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst.valid", 32'(ov1), 0);
    chk("rst.inst", io1, NOP);
    chk("rst.addr", ao1, 0);
    chk("rst.occ", 32'(oc1), 0);
    chk("rst.ready", 32'(ir1), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // backpressure table: A,B held, C waits upstream, then drained in order
    for (int k = 0; k < 7; k++) begin
      pre(tbl[k].iv, tbl[k].inst, tbl[k].addr, 1'b0, 1'b0, tbl[k].ordy);
      chk($sformatf("tbl%0d.valid", k), 32'(ov1), 32'(tbl[k].ov));
      chk($sformatf("tbl%0d.inst", k), io1, tbl[k].ei);
      chk($sformatf("tbl%0d.addr", k), ao1, tbl[k].ea);
      chk($sformatf("tbl%0d.occ", k), 32'(oc1), 32'(tbl[k].eo));
      chk($sformatf("tbl%0d.ready", k), 32'(ir1), 32'(tbl[k].ir));
      post();
    end
    // streaming at full rate
    for (int k = 0; k < 4; k++) step(1'b1, 32'h1000 + k, 32'(4 * k), 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 0, 1'b1);
    // hold_flag stall with ready high, then release
    step(1'b1, 32'h2000, 32'h20, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) step(1'b1, 32'h2000 + k, 32'h20 + 4 * k, 1'b0, 1'b1, 1'b1);
    pre(1'b0, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("hold.occ", 32'(oc1), 2);
    chk("hold.inst", io1, 32'h2000);
    post();
    repeat (4) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    // flush while full with a valid input in the same cycle
    step(1'b1, 32'h3000, 32'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3001, 32'h34, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3002, 32'h38, 1'b1, 1'b0, 1'b0);
    pre(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("flush.valid", 32'(ov1), 0);
    chk("flush.inst", io1, NOP);
    chk("flush.occ", 32'(oc1), 0);
    post();
    // asynchronous reset while full
    step(1'b1, 32'h4000, 32'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h4001, 32'h44, 1'b0, 1'b0, 1'b0);
    pre(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("arst.valid", 32'(ov1), 0);
    chk("arst.inst", io1, NOP);
    chk("arst.addr", ao1, 0);
    chk("arst.occ", 32'(oc1), 0);
    chk("arst.ready", 32'(ir1), 1);
    q1.delete(); q0.delete();
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h5000, 32'h50, 1'b0, 1'b0, 1'b1);
    pre(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("arst.first", io1, 32'h5000);
    post();
    // random traffic
    for (int k = 0; k < 600; k++)
      step(1'($urandom % 4 != 0), $urandom, $urandom, 1'($urandom % 17 == 0),
           1'($urandom % 5 == 0), 1'($urandom % 3 != 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
